pm_byte_feeder: RTL

Streams packet payload bytes into the NIDS pattern-matching pipeline, one character per clock on `input_ch`, and pairs the matcher's delayed `ifFinal` response with the byte offset and packet number that produced it. It sits upstream of the pattern top. It buffers bytes from the packet source in a small FIFO, inserts a zero-byte flush between packets so the automaton returns to root, and reports per-match and per-packet results.

---
 rtl/pm_pkg.sv | 29 ++
 rtl/pm_sync_fifo.sv | 75 +++++++
 rtl/pm_byte_feeder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pm_pkg.sv
// Shared types and constants for the pattern-matcher byte feeder:
// FSM state encoding, the per-byte match-window tag, and the flush character.
package pm_pkg;

  localparam int PM_POS_W = 11;
  localparam logic [7:0] FLUSH_CHAR = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } pm_state_e;

  typedef struct packed {
    logic                is_real;
    logic                last;
    logic [PM_POS_W-1:0] pos;
  } pm_tag_t;

  function automatic pm_tag_t pm_make_tag(input logic is_real, input logic last,
                                          input logic [PM_POS_W-1:0] pos);
    pm_tag_t t;
    t.is_real = is_real;
    t.last    = last;
    t.pos     = pos;
    return t;
  endfunction

endpackage

// File: rtl/pm_sync_fifo.sv
// Single-clock FIFO with show-ahead read data, full/empty flags and an
// occupancy count. Push while full and pop while empty are ignored.
module pm_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == CW'(0));
  assign count     = count_q;
  assign rdata     = mem_q[rd_ptr_q];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pm_byte_feeder.sv
// Feeds buffered packet bytes to the pattern matcher one per clock, flushes the
// automaton between packets, and pairs delayed ifFinal with byte position/packet.
module pm_byte_feeder
  import pm_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int MATCH_LAT  = 2,
  parameter int FLUSH_LEN  = 4,
  parameter int POS_W      = PM_POS_W,
  parameter int PKT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [7:0]       input_ch,
  input  logic             ifFinal,
  output logic             match_valid,
  output logic [POS_W-1:0] match_pos,
  output logic [PKT_W-1:0] match_pkt,
  output logic             pkt_done,
  output logic             pkt_hit,
  output logic             err_underrun
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = $clog2(FLUSH_LEN + 1);

  logic          fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s, rd_last_s;
  logic [8:0]    fifo_rdata_s;
  logic [CW-1:0] fifo_count_s;

  pm_state_e        state_q, state_d;
  logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [PKT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CW-1:0]    lasts_q, lasts_d;
  logic [7:0]       input_ch_q, input_ch_d;
  logic             err_q, err_d;

  pm_tag_t                         tag_in_s;
  logic [PKT_W-1:0]                pkt_in_s;
  pm_tag_t [MATCH_LAT-1:0]         tag_sr_q, tag_sr_d;
  logic [MATCH_LAT-1:0][PKT_W-1:0] pkt_sr_q, pkt_sr_d;
  pm_tag_t                         tail_q, tail_d;
  logic [PKT_W-1:0]                tail_pkt_q, tail_pkt_d;
  logic                            if_final_q, if_final_d;

  logic             new_match_s;
  logic             match_valid_q, match_valid_d;
  logic [POS_W-1:0] match_pos_q, match_pos_d;
  logic [PKT_W-1:0] match_pkt_q, match_pkt_d;
  logic             done_pend_q, done_pend_d;
  logic             hit_q, hit_d;
  logic             pkt_done_q, pkt_done_d;
  logic             pkt_hit_q, pkt_hit_d;

  assign fifo_push_s = s_valid && !fifo_full_s;
  assign rd_last_s   = fifo_rdata_s[8];
  assign s_ready     = !fifo_full_s;

  pm_sync_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (fifo_push_s),
    .wdata ({s_last, s_data}),
    .pop   (fifo_pop_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Packet sequencing: start/stream/flush decisions and the byte presented to the matcher
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pos_d       = pos_q;
    pkt_cnt_d   = pkt_cnt_q;
    input_ch_d  = FLUSH_CHAR;
    err_d       = err_q;
    fifo_pop_s  = 1'b0;
    tag_in_s    = pm_make_tag(1'b0, 1'b0, {PM_POS_W{1'b0}});
    pkt_in_s    = {PKT_W{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if ((lasts_q != CW'(0)) || (fifo_count_s == CW'(FIFO_DEPTH))) begin
          state_d = ST_STREAM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          input_ch_d = fifo_rdata_s[7:0];
          tag_in_s   = pm_make_tag(1'b1, rd_last_s, PM_POS_W'(pos_q));
          pkt_in_s   = pkt_cnt_q;
          if (rd_last_s) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = {FW{1'b0}};
            pos_d       = {POS_W{1'b0}};
            pkt_cnt_d   = pkt_cnt_q + PKT_W'(1);
          end else if (pos_q != {POS_W{1'b1}}) begin
            pos_d = pos_q + POS_W'(1);
          end else begin
            pos_d = pos_q;
          end
        end else begin
          err_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FW'(FLUSH_LEN - 1)) begin
          state_d     = ST_IDLE;
          flush_cnt_d = {FW{1'b0}};
        end else begin
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Number of buffered entries that close a packet, net of simultaneous push/pop
  always_comb begin
    lasts_d = lasts_q;
    if ((fifo_push_s && s_last) && !(fifo_pop_s && rd_last_s)) begin
      lasts_d = lasts_q + CW'(1);
    end else if (!(fifo_push_s && s_last) && (fifo_pop_s && rd_last_s)) begin
      lasts_d = lasts_q - CW'(1);
    end else begin
      lasts_d = lasts_q;
    end
  end

  // Tag delay line; the extra tail stage lines the tag up with the registered ifFinal
  always_comb begin
    tag_sr_d    = tag_sr_q;
    pkt_sr_d    = pkt_sr_q;
    tag_sr_d[0] = tag_in_s;
    pkt_sr_d[0] = pkt_in_s;
    for (int i = 1; i < MATCH_LAT; i++) begin
      tag_sr_d[i] = tag_sr_q[i-1];
      pkt_sr_d[i] = pkt_sr_q[i-1];
    end
    tail_d     = tag_sr_q[MATCH_LAT-1];
    tail_pkt_d = pkt_sr_q[MATCH_LAT-1];
    if_final_d = ifFinal;
  end

  // Match pairing and per-packet completion
  always_comb begin
    new_match_s   = tail_q.is_real && if_final_q;
    match_valid_d = new_match_s;
    if (new_match_s) begin
      match_pos_d = POS_W'(tail_q.pos);
      match_pkt_d = tail_pkt_q;
    end else begin
      match_pos_d = match_pos_q;
      match_pkt_d = match_pkt_q;
    end
    done_pend_d = tail_q.is_real && tail_q.last;
    hit_d       = (done_pend_q ? 1'b0 : hit_q) | new_match_s;
    pkt_done_d  = done_pend_q;
    pkt_hit_d   = done_pend_q && hit_q;
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= {FW{1'b0}};
      pos_q       <= {POS_W{1'b0}};
      pkt_cnt_q   <= {PKT_W{1'b0}};
      lasts_q     <= {CW{1'b0}};
      input_ch_q  <= FLUSH_CHAR;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      pos_q       <= pos_d;
      pkt_cnt_q   <= pkt_cnt_d;
      lasts_q     <= lasts_d;
      input_ch_q  <= input_ch_d;
      err_q       <= err_d;
    end
  end

  // Tag pipeline and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_sr_q      <= '0;
      pkt_sr_q      <= '0;
      tail_q        <= '0;
      tail_pkt_q    <= {PKT_W{1'b0}};
      if_final_q    <= 1'b0;
      match_valid_q <= 1'b0;
      match_pos_q   <= {POS_W{1'b0}};
      match_pkt_q   <= {PKT_W{1'b0}};
      done_pend_q   <= 1'b0;
      hit_q         <= 1'b0;
      pkt_done_q    <= 1'b0;
      pkt_hit_q     <= 1'b0;
    end else begin
      tag_sr_q      <= tag_sr_d;
      pkt_sr_q      <= pkt_sr_d;
      tail_q        <= tail_d;
      tail_pkt_q    <= tail_pkt_d;
      if_final_q    <= if_final_d;
      match_valid_q <= match_valid_d;
      match_pos_q   <= match_pos_d;
      match_pkt_q   <= match_pkt_d;
      done_pend_q   <= done_pend_d;
      hit_q         <= hit_d;
      pkt_done_q    <= pkt_done_d;
      pkt_hit_q     <= pkt_hit_d;
    end
  end

  assign input_ch     = input_ch_q;
  assign match_valid  = match_valid_q;
  assign match_pos    = match_pos_q;
  assign match_pkt    = match_pkt_q;
  assign pkt_done     = pkt_done_q;
  assign pkt_hit      = pkt_hit_q;
  assign err_underrun = err_q;

endmodule
